// File: rtl/prog_loader.sv
// prog_loader: writer end of the instruction-image interface. It takes a length-prefixed byte
// stream, packs bytes little-endian into 32-bit words and writes them to instruction memory from
// word 0, holding the CPU in reset until the image is complete.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data bytes.
module prog_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,      // active-high synchronous reset
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [1:0]        cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [16:0] Capacity = 17'(1) << ADDR_W;
  localparam logic [1:0]  CpuHold  = 2'b00;
  localparam logic [1:0]  CpuRun   = 2'b10;

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {StLenHi, StLenLo, StData, StCsum, StDone, StErr} state_e;
  localparam state_e StAfterData = StCsum;
`else
  typedef enum logic [2:0] {StLenHi, StLenLo, StData, StDone, StErr} state_e;
  localparam state_e StAfterData = StDone;
`endif

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        byte_q, byte_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [23:0]       pack_q, pack_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [1:0]        cpu_rst_n_q, cpu_rst_n_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        accept;
  logic [15:0] len_full;
  logic        word_end;
  logic        last_word;

  assign accept   = in_valid & in_ready_q;
  assign len_full = {len_q[15:8], in_data};
  assign word_end = accept && (state_q == StData) && (byte_q == 2'd3);
  // Word index compared in 17 bits so a full-capacity image still finds its last word.
  assign last_word = (({1'b0, len_q} - 17'd1) == 17'(word_q));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= StLenHi;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      StLenHi: if (accept) state_d = StLenLo;
      StLenLo: begin
        if (accept) begin
          if ({1'b0, len_full} > Capacity) begin
            state_d = StErr;
          end else if (len_full == 16'd0) begin
            state_d = StAfterData;
          end else begin
            state_d = StData;
          end
        end
      end
      // Leave DATA on the same edge that raises mem_we for the final word.
      StData: if (word_end && last_word) state_d = StAfterData;
`ifdef PROG_LOADER_CHECKSUM_EN
      StCsum: if (accept) state_d = (in_data == csum_q) ? StDone : StErr;
`endif
      StDone:  state_d = StDone;
      StErr:   state_d = StErr;
      default: state_d = StLenHi;
    endcase
  end

  // FSM status outputs
  always_comb begin
    busy = 1'b1;
    done = 1'b0;
    err  = 1'b0;
    case (state_q)
      StDone: begin
        busy = 1'b0;
        done = 1'b1;
      end
      StErr: begin
        busy = 1'b0;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next-state: length capture, byte packing, write strobe, checksum
  always_comb begin
    len_d       = len_q;
    byte_d      = byte_q;
    word_d      = word_q;
    pack_d      = pack_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    in_ready_d  = (state_d != StDone) && (state_d != StErr);
    // Release lags DONE by a cycle so the last write lands before the CPU starts.
    cpu_rst_n_d = (state_q == StDone) ? CpuRun : CpuHold;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    if (accept) begin
      case (state_q)
        StLenHi: len_d[15:8] = in_data;
        StLenLo: len_d[7:0]  = in_data;
        StData: begin
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          byte_d = byte_q + 2'd1;
          case (byte_q)
            2'd0:    pack_d[7:0]   = in_data;
            2'd1:    pack_d[15:8]  = in_data;
            2'd2:    pack_d[23:16] = in_data;
            default: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = word_q;
              mem_wdata_d = {in_data, pack_q};
              word_d      = word_q + ADDR_W'(1);
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst_n) begin
      len_q       <= '0;
      byte_q      <= '0;
      word_q      <= '0;
      pack_q      <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rst_n_q <= CpuHold;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      len_q       <= len_d;
      byte_q      <= byte_d;
      word_q      <= word_d;
      pack_q      <= pack_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rst_n = cpu_rst_n_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: drives byte-stream images into prog_loader and checks memory writes, latency,
// status and CPU release against a reference model built from the stream format rules.
module tb_prog_loader;

  localparam int unsigned ADDR_W = 10;
  localparam int          Cap    = 1 << ADDR_W;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data  = 8'h00;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [1:0]        cpu_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [7:0]        stim[$];
  logic [ADDR_W-1:0] act_addr[$];
  logic [31:0]       act_data[$];
  int                act_cyc[$];
  int                exp_cyc[$];
  int                rel_cyc  = -1;
  int                last_acc = -1;

  logic [ADDR_W-1:0] m_addr[$];
  logic [31:0]       m_data[$];
  logic              m_done;
  logic              m_err;

  // Write / release monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      act_addr.push_back(mem_addr);
      act_data.push_back(mem_wdata);
      act_cyc.push_back(cyc);
    end
    if (cpu_rst_n === 2'b10 && rel_cyc < 0) rel_cyc = cyc;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);
    rst_n = 1'b0;
    act_addr.delete();
    act_data.delete();
    act_cyc.delete();
    exp_cyc.delete();
    rel_cyc  = -1;
    last_acc = -1;
  endtask

  // Reference: N words little-endian from the data bytes; N > capacity rejects the image;
  // with the checksum option the trailing byte must equal the XOR of all data bytes.
  task automatic model();
    int         n;
    logic [7:0] cs;
    logic [31:0] w;
    m_addr.delete();
    m_data.delete();
    m_done = 1'b0;
    m_err  = 1'b0;
    n = int'({stim[0], stim[1]});
    if (n > Cap) begin
      m_err = 1'b1;
      return;
    end
    cs = 8'h00;
    for (int k = 0; k < n; k++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++) begin
        w  = w | (32'(stim[2 + 4 * k + j]) << (8 * j));
        cs = cs ^ stim[2 + 4 * k + j];
      end
      m_addr.push_back(ADDR_W'(k));
      m_data.push_back(w);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    if (stim.size() > 2 + 4 * n && stim[2 + 4 * n] == cs) m_done = 1'b1;
    else m_err = 1'b1;
`else
    m_done = 1'b1;
`endif
  endtask

  task automatic add_csum();
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] cs;
    cs = 8'h00;
    for (int i = 2; i < stim.size(); i++) cs = cs ^ stim[i];
    stim.push_back(cs);
`endif
  endtask

  // gap: 0 full rate, 1 valid toggles 1-0-1, 2 random valid
  task automatic send(input int count, input int gap);
    int n;
    int waitc;
    bit acc;
    bit tog;
    n   = int'({stim[0], stim[1]});
    tog = 1'b1;
    for (int i = 0; i < count; i++) begin
      acc   = 1'b0;
      waitc = 0;
      while (!acc) begin
        in_data = stim[i];
        case (gap)
          0:       in_valid = 1'b1;
          1:       in_valid = tog;
          default: in_valid = 1'($urandom_range(0, 1));
        endcase
        tog = ~tog;
        acc = (in_valid === 1'b1) && (in_ready === 1'b1);
        if (acc) begin
          last_acc = cyc + 1;
          if (i >= 2 && i < 2 + 4 * n && ((i - 2) % 4) == 3) exp_cyc.push_back(cyc + 1);
        end
        @(negedge clk);
        if (!acc) begin
          waitc++;
          if (waitc > 64) begin
            total++;
            bad++;
            $display("FAIL send_timeout: byte %0d not taken after %0d cycles, in_ready=%b want 1",
                     i, waitc, in_ready);
            in_valid = 1'b0;
            return;
          end
        end
      end
    end
    in_valid = 1'b0;
  endtask

  // Load the current stim and check writes, latency, status and release timing
  task automatic test_load(input string name, input int gap);
    model();
    send(stim.size(), gap);
    idle(3);
    total++;
    if (act_addr.size() !== m_addr.size()) begin
      bad++;
      $display("FAIL %s_count: got %0d writes want %0d", name, act_addr.size(), m_addr.size());
    end
    for (int k = 0; k < m_addr.size() && k < act_addr.size(); k++) begin
      total++;
      if (act_addr[k] !== m_addr[k] || act_data[k] !== m_data[k]) begin
        bad++;
        $display("FAIL %s_word%0d: got addr=%h data=%h want addr=%h data=%h", name, k,
                 act_addr[k], act_data[k], m_addr[k], m_data[k]);
      end
    end
    for (int k = 0; k < exp_cyc.size() && k < act_cyc.size(); k++) begin
      total++;
      if (act_cyc[k] !== exp_cyc[k]) begin
        bad++;
        $display("FAIL %s_latency%0d: write at cycle %0d want %0d", name, k, act_cyc[k],
                 exp_cyc[k]);
      end
    end
    total++;
    if (done !== m_done || err !== m_err) begin
      bad++;
      $display("FAIL %s_status: got done=%b err=%b want done=%b err=%b", name, done, err,
               m_done, m_err);
    end
    total++;
    if (m_done && rel_cyc !== last_acc + 1) begin
      bad++;
      $display("FAIL %s_release: cpu_rst_n=10 at cycle %0d want %0d", name, rel_cyc,
               last_acc + 1);
    end else if (!m_done && rel_cyc !== -1) begin
      bad++;
      $display("FAIL %s_release: cpu_rst_n=10 at cycle %0d want never", name, rel_cyc);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    total++;
    if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    total++;
    if (mem_addr !== '0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    total++;
    if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
    total++;
    if (cpu_rst_n !== 2'b00) begin bad++; $display("FAIL reset_cpu: got %b want 00", cpu_rst_n); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", busy); end
    total++;
    if (done !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: got done=%b err=%b want 0 0", done, err);
    end
    idle(1);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after: got %b want 1", in_ready); end
  endtask

  task automatic basic_stim();
    stim = '{8'h00, 8'h02, 8'h13, 8'h04, 8'h00, 8'h04, 8'h13, 8'h03, 8'h00, 8'h04};
    add_csum();
  endtask

  task automatic test_basic();
    do_reset();
    basic_stim();
    test_load("basic", 0);
    total++;
    if (act_data.size() < 2) begin
      bad++;
      $display("FAIL basic_fixed: got %0d writes want 2", act_data.size());
    end else if (act_addr[0] !== 10'h000 || act_data[0] !== 32'h04000413 ||
                 act_addr[1] !== 10'h001 || act_data[1] !== 32'h04000313) begin
      bad++;
      $display("FAIL basic_fixed: got %h:%h %h:%h want 000:04000413 001:04000313",
               act_addr[0], act_data[0], act_addr[1], act_data[1]);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    basic_stim();
    test_load("gaps", 1);
  endtask

  task automatic test_zero_len();
    int rdy;
    do_reset();
    stim = '{8'h00, 8'h00};
    add_csum();
    test_load("zero", 0);
    // Bytes offered after DONE must be refused
    rdy = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      if (in_ready !== 1'b0) rdy++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    idle(2);
    total++;
    if (rdy !== 0 || act_addr.size() !== 0) begin
      bad++;
      $display("FAIL zero_extra: got ready_cycles=%0d writes=%0d want 0 0", rdy, act_addr.size());
    end
  endtask

  task automatic test_oversize();
    int n;
    do_reset();
    stim = '{8'h04, 8'h01};
    test_load("oversize", 0);
    total++;
    if (cpu_rst_n !== 2'b00 || busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL oversize_outs: got cpu=%b busy=%b ready=%b want 00 0 0", cpu_rst_n, busy,
               in_ready);
    end
    do_reset();
    n = $urandom_range(Cap + 1, 65535);
    stim = '{8'(n >> 8), 8'(n)};
    test_load("oversize_rand", 0);
  endtask

  task automatic test_full();
    do_reset();
    stim = '{8'h04, 8'h00};
    for (int k = 0; k < Cap; k++) begin
      stim.push_back(8'(k));
      stim.push_back(8'(k >> 8));
      stim.push_back(8'h00);
      stim.push_back(8'h00);
    end
    add_csum();
    test_load("full", 0);
    total++;
    if (act_addr.size() !== Cap) begin
      bad++;
      $display("FAIL full_count: got %0d want %0d", act_addr.size(), Cap);
    end else if (act_addr[Cap-1] !== 10'h3FF || act_data[Cap-1] !== 32'h000003FF) begin
      bad++;
      $display("FAIL full_last: got %h:%h want 3ff:000003ff", act_addr[Cap-1], act_data[Cap-1]);
    end
  endtask

  task automatic rand_image(input int n);
    stim = '{8'(n >> 8), 8'(n)};
    for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
    add_csum();
  endtask

  task automatic test_reset_mid();
    do_reset();
    rand_image(3);
    send(2 + 4 + 2, 0);
    idle(2);
    total++;
    if (act_addr.size() !== 1) begin
      bad++;
      $display("FAIL mid_partial: got %0d writes want 1", act_addr.size());
    end
    do_reset();
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0 || cpu_rst_n !== 2'b00) begin
      bad++;
      $display("FAIL mid_reset_state: got busy=%b done=%b err=%b cpu=%b want 1 0 0 00", busy,
               done, err, cpu_rst_n);
    end
    rand_image(4);
    test_load("mid_reload", 2);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      do_reset();
      rand_image($urandom_range(1, 6));
      test_load("rand", $urandom_range(0, 2));
    end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    stim = '{8'h00, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    test_load("csum_good", 0);
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL csum_good_done: got %b want 1", done); end
    do_reset();
    stim = '{8'h00, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    test_load("csum_bad", 0);
    total++;
    if (err !== 1'b1 || cpu_rst_n !== 2'b00) begin
      bad++;
      $display("FAIL csum_bad_err: got err=%b cpu=%b want 1 00", err, cpu_rst_n);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_reset();
    test_gaps();
    test_zero_len();
    test_oversize();
    test_full();
    test_reset_mid();
    test_random();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
